fifo_sync_fwft: RTL and testbench
=================================

Name: fifo_sync_fwft

Overview:
- Synchronous first-word-fall-through FIFO for single-clock queues, e.g. a load/store or fetch queue in front of the core.
- Built on an internal block-RAM array with one write port and one registered read port.
- Hides the RAM's one-cycle read latency, so the consumer sees a valid/ready stream where head data is already present on rd_data.
- Tracks occupancy and flags overflow and underflow misuse.

Parameters:
- DATAWIDTH, 32, width of each entry.
- ADDRWIDTH, 4, log2 of depth; capacity is 2^ADDRWIDTH entries.
- AFULL_LEVEL, 12, almost_full asserts when count >= AFULL_LEVEL; legal range 1..2^ADDRWIDTH.

Ports:
- clk  in  1  clock, rising edge.
- reset_l  in  1  asynchronous active-low reset.
- wr_data  in  DATAWIDTH  push data.
- we  in  1  push request; accepted only when full=0.
- full  out  1  count == 2^ADDRWIDTH.
- almost_full  out  1  count >= AFULL_LEVEL.
- rd_data  out  DATAWIDTH  head entry; meaningful only when rd_valid=1.
- rd_valid  out  1  FIFO non-empty (count != 0).
- rd_ready  in  1  pop; takes effect only when rd_valid=1.
- count  out  ADDRWIDTH+1  number of stored entries.
- ovf  out  1  sticky: set by we=1 while full=1.
- unf  out  1  sticky: set by rd_ready=1 while rd_valid=0.
- err_clr  in  1  synchronous clear of ovf and unf.

Behaviour:
- Reset (async assert, sync-safe deassert): wr_ptr=0, rd_ptr=0, count=0, full=0, almost_full=0, rd_valid=0, ovf=0, unf=0, rd_data=0. The RAM array is not cleared.
- push = we & ~full. pop = rd_ready & rd_valid.
- On push: write ram[wr_ptr] = wr_data; wr_ptr increments mod 2^ADDRWIDTH.
- Read address is combinational: rd_ptr+1 when pop, else rd_ptr. The RAM output register loads ram[read address] every cycle, and rd_data is that register. On pop, rd_ptr increments mod 2^ADDRWIDTH.
- The storage must be write-first: a read of the address being written in the same cycle returns the new data. This is what gives a write-to-rd_valid latency of exactly 1 cycle with correct rd_data, including when the FIFO is empty.
- count_next = count + push - pop. Flags are registered and derived from count_next, so they agree with count every cycle.
- Push while full: dropped, no state change except ovf<=1. A pop in the same cycle does not make room for that push.
- Pop while empty: ignored, unf<=1.
- Push and pop in the same cycle, 0 < count < full: count unchanged, both pointers advance.
- Push and pop at count=1: the head is consumed. The new entry appears on rd_data in the next cycle with rd_valid still 1.
- rd_data must hold stable while rd_valid=1 and rd_ready=0, including while pushes continue.
- err_clr has priority below a same-cycle set: if err_clr=1 and a new violation occurs, the flag stays 1.
- Pointer wrap: pointers are ADDRWIDTH bits and wrap naturally. Full/empty come only from count, never from pointer comparison.

Decomposition:
- Shared package: FIFO depth constant function (1<<ADDRWIDTH) and count width (ADDRWIDTH+1).
- One sub-module: fifo_ram_wf, a write-first dual-port RAM (DATAWIDTH, ADDRWIDTH) with registered read. All control stays in fifo_sync_fwft.

Test Plan:
- Reset, then push 0xA5 in one cycle -> next cycle rd_valid=1, rd_data=0xA5, count=1. Pop -> next cycle rd_valid=0, count=0.
- Push 16 entries 0..15 with rd_ready=0 (ADDRWIDTH=4) -> full=1, count=16, almost_full from count=12. 17th push -> dropped, ovf=1. Drain -> outputs 0..15 in order.
- Continuous push and pop each cycle for 40 cycles, starting from count=1 -> count stays 1, data in order across two pointer wraps, rd_data correct on the cycle after each write.
- Full FIFO with we=1 and rd_ready=1 together -> pop succeeds, push dropped, count=15, ovf=1.
- rd_ready=1 while empty -> unf=1. err_clr=1 for one cycle -> unf=0. err_clr=1 plus a new underflow in the same cycle -> unf stays 1.
- Assert reset_l=0 mid-stream at count=7 -> outputs reset immediately without waiting for clk. After release, push 0x3C -> rd_data=0x3C with no stale data visible.

Source files
------------

// File: rtl/fifo_sync_fwft_pkg.sv
// Shared sizing helpers for the first-word-fall-through FIFO and its RAM.
// Latency/backpressure: n/a (compile-time constants only).
package fifo_sync_fwft_pkg;

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  // One extra bit so the count can represent a completely full FIFO.
  function automatic int fifo_cnt_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/fifo_ram_wf.sv
// Write-first simple dual-port RAM with registered read port.
// Latency: 1 cycle read; no backpressure (accepts a write and a read every cycle).
module fifo_ram_wf
  import fifo_sync_fwft_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_we,
  input  logic [ADDRWIDTH-1:0] i_waddr,
  input  logic [DATAWIDTH-1:0] i_wdata,
  input  logic [ADDRWIDTH-1:0] i_raddr,
  output logic [DATAWIDTH-1:0] o_rdata
);

  localparam int DEPTH = fifo_depth(ADDRWIDTH);

  logic [DATAWIDTH-1:0] r_mem [DEPTH];
  logic [DATAWIDTH-1:0] r_rdata;
  logic                 w_collide;

  // Array contents are deliberately left unreset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign w_collide = i_we && (i_waddr == i_raddr);

  // Same-address read returns the data being written this cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (w_collide) begin
      r_rdata <= i_wdata;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_sync_fwft.sv
// Single-clock FWFT FIFO over a registered-read RAM; head data is presented with rd_valid.
// Latency: write to rd_valid 1 cycle; backpressure: pushes dropped while full, rd_ready holds head.
module fifo_sync_fwft
  import fifo_sync_fwft_pkg::*;
#(
  parameter int DATAWIDTH   = 32,
  parameter int ADDRWIDTH   = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic [DATAWIDTH-1:0] wr_data,
  input  logic                 we,
  output logic                 full,
  output logic                 almost_full,
  output logic [DATAWIDTH-1:0] rd_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [ADDRWIDTH:0]   count,
  output logic                 ovf,
  output logic                 unf,
  input  logic                 err_clr
);

  localparam int DEPTH = fifo_depth(ADDRWIDTH);
  localparam int CW    = fifo_cnt_width(ADDRWIDTH);

  logic [ADDRWIDTH-1:0] r_wr_ptr;
  logic [ADDRWIDTH-1:0] r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_full;
  logic                 r_afull;
  logic                 r_rd_valid;
  logic                 r_ovf;
  logic                 r_unf;

  logic                 w_push;
  logic                 w_pop;
  logic [ADDRWIDTH-1:0] w_rd_addr;
  logic [CW-1:0]        w_count_next;
  logic                 w_ovf_next;
  logic                 w_unf_next;
  logic [DATAWIDTH-1:0] w_ram_rdata;

  assign w_push = we && !r_full;
  assign w_pop  = rd_ready && r_rd_valid;

  // Look one entry ahead on pop so the next head is already registered when it is needed.
  assign w_rd_addr    = w_pop ? (r_rd_ptr + ADDRWIDTH'(1)) : r_rd_ptr;
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

  // A same-cycle violation outranks err_clr.
  assign w_ovf_next = (r_ovf && !err_clr) || (we && r_full);
  assign w_unf_next = (r_unf && !err_clr) || (rd_ready && !r_rd_valid);

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDRWIDTH'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDRWIDTH'(1);
      end
    end
  end

  // Status flags come from the next count so they always agree with r_count.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_count    <= '0;
      r_full     <= 1'b0;
      r_afull    <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_count    <= w_count_next;
      r_full     <= (w_count_next == CW'(DEPTH));
      r_afull    <= (w_count_next >= CW'(AFULL_LEVEL));
      r_rd_valid <= (w_count_next != '0);
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_next;
      r_unf <= w_unf_next;
    end
  end

  fifo_ram_wf #(
    .DATAWIDTH (DATAWIDTH),
    .ADDRWIDTH (ADDRWIDTH)
  ) u_ram (
    .i_clk   (clk),
    .i_rst_n (reset_l),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (wr_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_ram_rdata)
  );

  assign rd_data     = w_ram_rdata;
  assign rd_valid    = r_rd_valid;
  assign count       = r_count;
  assign full        = r_full;
  assign almost_full = r_afull;
  assign ovf         = r_ovf;
  assign unf         = r_unf;

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// Bench for fifo_sync_fwft: directed scenarios plus random traffic against a queue-based model.
module tb_fifo_sync_fwft;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int AF    = 12;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset_l = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          we = 1'b0;
  logic          full;
  logic          almost_full;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [AW:0]   count;
  logic          ovf;
  logic          unf;
  logic          err_clr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  bit mdl_en = 1'b0;

  logic [DW-1:0] m_q[$];
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;
  bit            m_full_now;

  fifo_sync_fwft #(
    .DATAWIDTH   (DW),
    .ADDRWIDTH   (AW),
    .AFULL_LEVEL (AF)
  ) dut (
    .clk         (clk),
    .reset_l     (reset_l),
    .wr_data     (wr_data),
    .we          (we),
    .full        (full),
    .almost_full (almost_full),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .count       (count),
    .ovf         (ovf),
    .unf         (unf),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of stored words plus the two sticky error bits.
  always @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_full_now = (m_q.size() == DEPTH);
      m_ovf = (m_ovf && !err_clr) || (we && m_full_now);
      m_unf = (m_unf && !err_clr) || (rd_ready && m_q.size() == 0);
      if (rd_ready && m_q.size() != 0) void'(m_q.pop_front());
      if (we && !m_full_now) m_q.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    if (mdl_en) begin
      chk("m_count", 32'(count), 32'(m_q.size()));
      chk("m_full", 32'(full), 32'(m_q.size() == DEPTH));
      chk("m_afull", 32'(almost_full), 32'(m_q.size() >= AF));
      chk("m_rd_valid", 32'(rd_valid), 32'(m_q.size() != 0));
      chk("m_ovf", 32'(ovf), 32'(m_ovf));
      chk("m_unf", 32'(unf), 32'(m_unf));
      if (m_q.size() != 0) chk("m_rd_data", rd_data, m_q[0]);
    end
  end

  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input logic e);
    we = w;
    wr_data = d;
    rd_ready = r;
    err_clr = e;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k = 0;
    while (rd_valid && k < 20) begin
      cyc(1'b0, '0, 1'b1, 1'b1);
      k++;
    end
    chk("drain_done", 32'(rd_valid), 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int wp;
    int rp;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_unf", 32'(unf), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    reset_l = 1'b1;
    mdl_en = 1'b1;

    // Single word fall-through
    cyc(1'b1, 32'hA5, 1'b0, 1'b0);
    chk("a5_valid", 32'(rd_valid), 32'd1);
    chk("a5_data", rd_data, 32'hA5);
    chk("a5_count", 32'(count), 32'd1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("a5_pop_valid", 32'(rd_valid), 32'd0);
    chk("a5_pop_count", 32'(count), 32'd0);

    // Fill to full, overflow, drain in order
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, DW'(i), 1'b0, 1'b0);
      chk("fill_afull", 32'(almost_full), 32'(i + 1 >= 12));
    end
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_full", 32'(full), 32'd1);
    cyc(1'b1, 32'h99, 1'b0, 1'b0);
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", rd_data, DW'(i));
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
    chk("drain_count", 32'(count), 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(ovf), 32'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 16; i++) cyc(1'b1, DW'(100 + i), 1'b0, 1'b0);
    cyc(1'b1, 32'd77, 1'b1, 1'b0);
    chk("fullpp_count", 32'(count), 32'd15);
    chk("fullpp_ovf", 32'(ovf), 32'd1);
    chk("fullpp_data", rd_data, 32'd101);
    drain();
    chk("fullpp_ovf_clr", 32'(ovf), 32'd0);

    // Streaming at count=1 across pointer wraps
    cyc(1'b1, 32'd200, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, DW'(201 + i), 1'b1, 1'b0);
      chk("stream_count", 32'(count), 32'd1);
      chk("stream_data", rd_data, DW'(201 + i));
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("stream_end", 32'(count), 32'd0);

    // Underflow and clear priority
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("unf_set", 32'(unf), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("unf_clr", 32'(unf), 32'd0);
    cyc(1'b0, '0, 1'b1, 1'b1);
    chk("unf_clr_prio", 32'(unf), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b1);

    // Random traffic in four load phases
    for (int i = 0; i < 800; i++) begin
      case (i / 200)
        0:       begin wp = 70; rp = 30; end
        1:       begin wp = 30; rp = 70; end
        2:       begin wp = 50; rp = 50; end
        default: begin wp = 90; rp = 90; end
      endcase
      cyc(1'($urandom_range(0, 99) < wp), DW'($urandom), 1'($urandom_range(0, 99) < rp),
          1'($urandom_range(0, 31) == 0));
    end
    drain();

    // Asynchronous reset mid-stream
    for (int i = 0; i < 7; i++) cyc(1'b1, DW'(50 + i), 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd7);
    #3;
    reset_l = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_valid", 32'(rd_valid), 32'd0);
    chk("arst_afull", 32'(almost_full), 32'd0);
    chk("arst_rd_data", rd_data, 32'd0);
    @(posedge clk);
    #1;
    reset_l = 1'b1;
    cyc(1'b1, 32'h3C, 1'b0, 1'b0);
    chk("post_rst_data", rd_data, 32'h3C);
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_valid", 32'(rd_valid), 32'd1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);

    mdl_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
